// File: rtl/pe_acc_drain.sv
// pe_acc_drain: systolic MAC element with tagged operands, result hold register and column drain chain
module pe_acc_drain #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 24,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_vld_in,
    input  logic              last_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              b_vld_in,
    output logic [DATA_W-1:0] a_out,
    output logic              a_vld_out,
    output logic              last_out,
    output logic [DATA_W-1:0] b_out,
    output logic              b_vld_out,
    input  logic              load_en,
    input  logic              shift_en,
    input  logic [ACC_W-1:0]  chain_in,
    input  logic              chain_sat_in,
    input  logic              chain_vld_in,
    output logic [ACC_W-1:0]  chain_out,
    output logic              chain_sat_out,
    output logic              chain_vld_out,
    output logic              ovr
);
    localparam int PW = 2 * DATA_W;
    localparam int XW = ACC_W + 1 - PW;

    logic              fire;
    logic signed [PW-1:0] ps;
    logic [PW-1:0]     pu;
    logic [ACC_W:0]    p_ext;
    logic [ACC_W:0]    acc_ext;
    logic [ACC_W:0]    sum;
    logic              ovf;
    logic [ACC_W-1:0]  clamp;
    logic [ACC_W-1:0]  res;
    logic [ACC_W-1:0]  acc;
    logic              sat;
    logic [ACC_W-1:0]  hold;
    logic              hold_sat;
    logic              hold_vld;

    // Product, widened sum and overflow clamp; sum carries one guard bit so overflow is visible
    always_comb begin
        fire    = a_vld_in & b_vld_in;
        ps      = $signed(a_in) * $signed(b_in);
        pu      = a_in * b_in;
        p_ext   = (SIGNED != 0) ? {{XW{ps[PW-1]}}, ps} : {{XW{1'b0}}, pu};
        acc_ext = (SIGNED != 0) ? {acc[ACC_W-1], acc} : {1'b0, acc};
        sum     = acc_ext + p_ext;
        ovf     = (SATURATE != 0) & ((SIGNED != 0) ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W]);
        clamp   = (SIGNED != 0) ? (sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}})
                                : {ACC_W{1'b1}};
        res     = ovf ? clamp : sum[ACC_W-1:0];
    end

    // Row and column operand forwarding, unconditional every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_out     <= '0;
            a_vld_out <= 1'b0;
            last_out  <= 1'b0;
            b_out     <= '0;
            b_vld_out <= 1'b0;
        end else begin
            a_out     <= a_in;
            a_vld_out <= a_vld_in;
            last_out  <= last_in;
            b_out     <= b_in;
            b_vld_out <= b_vld_in;
        end
    end

    // Accumulate, capture completed dot products into hold, flag dropped results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            sat      <= 1'b0;
            hold     <= '0;
            hold_sat <= 1'b0;
            hold_vld <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            if (fire & !last_in) begin
                acc <= res;
                sat <= sat | ovf;
            end
            if (fire & last_in) begin
                acc <= '0;
                sat <= 1'b0;
                if (!hold_vld | load_en) begin
                    hold     <= res;
                    hold_sat <= sat | ovf;
                    hold_vld <= 1'b1;
                end else begin
                    ovr <= 1'b1;
                end
            end else if (load_en) begin
                hold_vld <= 1'b0;
            end
        end
    end

    // Drain chain: parallel load from hold takes priority over shifting from the PE above
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_out     <= '0;
            chain_sat_out <= 1'b0;
            chain_vld_out <= 1'b0;
        end else if (load_en) begin
            chain_out     <= hold;
            chain_sat_out <= hold_sat;
            chain_vld_out <= hold_vld;
        end else if (shift_en) begin
            chain_out     <= chain_in;
            chain_sat_out <= chain_sat_in;
            chain_vld_out <= chain_vld_in;
        end
    end
endmodule
